lfsr_sched: RTL

- Controller and arbiter for the 6-bit shift-register random source (taps: q0<=q5, q1<=q0, q2<=q1, q3<=q2^q5, q4<=q3, q5<=q4).
- Loads a seed, measures the cycle length from that seed, runs a configurable warm-up, then serves one random word per cycle to NREQ requesters in round-robin order.
- Sits between the random source and its consumers, e.g. test-pattern generators and backoff counters.

---
 rtl/lfsr_sched_pkg.sv | 25 ++
 rtl/lfsr6_step.sv | 15 +
 rtl/lfsr_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lfsr_sched_pkg.sv
// Shared types and constants for the LFSR scheduler.
// Holds the controller state encoding, the LFSR geometry and the
// measurement bound used by lfsr_sched and lfsr6_step.
package lfsr_sched_pkg;

  localparam int unsigned LFSR_W = 6;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned RR_W   = 2;
  localparam int unsigned MEAS_MAX = 63;
  localparam logic [LFSR_W-1:0] LFSR_INIT = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_WARMUP  = 2'd2,
    ST_SERVE   = 2'd3
  } state_t;

  // The all-zero state is a fixed point of the shift register, so it is
  // never allowed in as a seed.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_INIT : s;
  endfunction

endpackage

// File: rtl/lfsr6_step.sv
// One step of the 6-bit shift-register random source.
// Ports:
//   q        current register value
//   q_next_c combinational next value
// Taps: q0<=q5, q1<=q0, q2<=q1, q3<=q2^q5, q4<=q3, q5<=q4.
module lfsr6_step
  import lfsr_sched_pkg::*;
(
  input  logic [LFSR_W-1:0] q,
  output logic [LFSR_W-1:0] q_next_c
);

  assign q_next_c = {q[4], q[3], q[2] ^ q[5], q[1], q[0], q[5]};

endmodule

// File: rtl/lfsr_sched.sv
// Seed loader, period meter, warm-up sequencer and round-robin server
// for the 6-bit random source.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   seed_we/seed load a new seed (zero maps to 6'h3F) and restart measurement
//   req          level-sensitive per-requester requests, honoured in SERVE only
//   gnt          registered one-hot grant; rnd_valid mirrors |gnt
//   rnd          random word delivered with the grant
//   busy         high while measuring or warming up
//   cycle_len    measured period of the last seed (0 = no return within bound)
//   len_valid    cycle_len holds a result for the current seed
module lfsr_sched
  import lfsr_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned WARMUP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_we,
  input  logic [LFSR_W-1:0] seed,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic              rnd_valid,
  output logic [LFSR_W-1:0] rnd,
  output logic              busy,
  output logic [LFSR_W-1:0] cycle_len,
  output logic              len_valid
);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP == 0) ? 0 : WARMUP - 1);

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr, lfsr_nxt;
  logic [LFSR_W-1:0] seed_reg, seed_reg_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [RR_W-1:0]   rr, rr_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic              rnd_valid_nxt;
  logic [LFSR_W-1:0] rnd_nxt;
  logic [LFSR_W-1:0] cycle_len_nxt;
  logic              len_valid_nxt;
  logic [LFSR_W-1:0] lfsr_step_c;
  logic              found;
  int                win;

  // The stepped value serves both for advancing and for the period compare.
  lfsr6_step u_step (
    .q        (lfsr),
    .q_next_c (lfsr_step_c)
  );

  assign busy = (state == ST_MEASURE) || (state == ST_WARMUP);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    seed_reg_nxt  = seed_reg;
    cnt_nxt       = cnt;
    rr_nxt        = rr;
    gnt_nxt       = '0;
    rnd_valid_nxt = 1'b0;
    rnd_nxt       = rnd;
    cycle_len_nxt = cycle_len;
    len_valid_nxt = len_valid;
    found         = 1'b0;
    win           = 0;

    // Round-robin search: first requester at or after rr, wrapping.
    for (int i = 0; i < int'(NREQ); i++) begin
      for (int j = 0; j < int'(NREQ); j++) begin
        if (!found && req[j] && (j == (int'(rr) + i) % int'(NREQ))) begin
          found = 1'b1;
          win   = j;
        end
      end
    end

    if (seed_we) begin
      state_nxt     = ST_MEASURE;
      lfsr_nxt      = seed_fix(seed);
      seed_reg_nxt  = seed_fix(seed);
      cnt_nxt       = '0;
      len_valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_MEASURE: begin
          lfsr_nxt = lfsr_step_c;
          if (lfsr_step_c == seed_reg) begin
            cycle_len_nxt = LFSR_W'(cnt + CNT_W'(1));
            len_valid_nxt = 1'b1;
            state_nxt     = ST_WARMUP;
            cnt_nxt       = '0;
          end else if (cnt == CNT_W'(MEAS_MAX)) begin
            cycle_len_nxt = '0;
            len_valid_nxt = 1'b1;
            state_nxt     = ST_WARMUP;
            cnt_nxt       = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_WARMUP: begin
          if (WARMUP == 0) begin
            state_nxt = ST_SERVE;
          end else begin
            lfsr_nxt = lfsr_step_c;
            if (cnt == WARM_LAST) begin
              state_nxt = ST_SERVE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        ST_SERVE: begin
          if (found) begin
            gnt_nxt       = NREQ'(1) << win;
            rnd_nxt       = lfsr;
            rnd_valid_nxt = 1'b1;
            lfsr_nxt      = lfsr_step_c;
            rr_nxt        = RR_W'((win + 1) % int'(NREQ));
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lfsr      <= LFSR_INIT;
      seed_reg  <= LFSR_INIT;
      cnt       <= '0;
      rr        <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd       <= '0;
      cycle_len <= '0;
      len_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      seed_reg  <= seed_reg_nxt;
      cnt       <= cnt_nxt;
      rr        <= rr_nxt;
      gnt       <= gnt_nxt;
      rnd_valid <= rnd_valid_nxt;
      rnd       <= rnd_nxt;
      cycle_len <= cycle_len_nxt;
      len_valid <= len_valid_nxt;
    end
  end

endmodule
